// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display paths: digit count,
// the all-off pattern and the active-low hex glyph table (seg[0]=a .. seg[6]=g).
package seg7_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Index = nibble value. Lower-case b and d keep them distinct from 8 and 0.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, // 0
    7'h79, // 1
    7'h24, // 2
    7'h30, // 3
    7'h19, // 4
    7'h12, // 5
    7'h02, // 6
    7'h78, // 7
    7'h00, // 8
    7'h10, // 9
    7'h08, // A
    7'h03, // b
    7'h46, // C
    7'h21, // d
    7'h06, // E
    7'h0E  // F
  };

endpackage

// File: rtl/seg7_scan_hex_to_seg7.sv
// Nibble to active-low seven-segment glyph. Purely combinational so the
// LED/debug paths can reuse it without pulling in any timing.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup; every code 0-F has a defined glyph.
  always_comb begin
    seg = GLYPH[nib];
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A load strobe copies the front-end value into a shadow register so a scan
// never shows a half-updated number. Each digit slot opens with one all-off
// cycle to stop ghosting when the anode changes.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  input  logic        lz_blank,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  // shadow copy of the front-end inputs
  logic [15:0]      val_p0;
  logic [3:0]       dp_p0;
  logic [3:0]       blank_p0;
  logic             lz_p0;

  // scan position
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  // decode of the active digit
  logic [3:0]       nib;
  logic [6:0]       glyph;
  logic [3:0]       lz_mask;
  logic             zero_run;
  logic             dark;

  // Shadow capture: only on the load strobe, so the display holds otherwise.
  always_ff @(posedge mclk) begin
    if (rst) begin
      val_p0   <= '0;
      dp_p0    <= '0;
      blank_p0 <= '0;
      lz_p0    <= 1'b0;
    end else if (load) begin
      val_p0   <= value;
      dp_p0    <= dp_in;
      blank_p0 <= blank;
      lz_p0    <= lz_blank;
    end
  end

  // Prescaler sweeps one slot; its wrap steps the digit index round-robin.
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 is never suppressed so a zero value still shows "0".
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_run   = zero_run & (val_p0[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  // Select the active nibble and decide whether its segments are forced dark.
  always_comb begin
    nib  = val_p0[{idx, 2'b00} +: 4];
    dark = blank_p0[idx] | (lz_p0 & lz_mask[idx]);
  end

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (glyph)
  );

  // Output registers: all off on the first cycle of each slot, otherwise
  // the active anode with its glyph. A dark digit keeps its anode and dp.
  always_ff @(posedge mclk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (cnt == '0) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= dark ? SEG_OFF : glyph;
      dp  <= ~dp_p0[idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: a reference model predicts each cycle's pins from
// elapsed time since reset and the last loaded inputs; a monitor process
// compares the DUT against the queued predictions.
module tb_seg7_scan;

  localparam int P = 4;

  logic        mclk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        lz_blank;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  always #5 mclk = ~mclk;

  seg7_scan #(.PRESCALE(P)) dut (
    .mclk     (mclk),
    .rst      (rst),
    .value    (value),
    .dp_in    (dp_in),
    .blank    (blank),
    .lz_blank (lz_blank),
    .load     (load),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } pins_t;

  pins_t expq[$];
  int    tests = 0;
  int    fails = 0;

  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state: cycles since reset release and the latched inputs
  int          t;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic        m_lz;

  function automatic pins_t model_out();
    pins_t      o;
    int         phase;
    int         digit;
    logic [15:0] upper;
    logic       darkd;
    o.an  = 4'b1111;
    o.seg = 7'b1111111;
    o.dp  = 1'b1;
    if (rst) return o;
    phase = t % P;
    digit = (t / P) % 4;
    if (phase == 0) return o;
    upper = m_val >> (4 * digit);
    darkd = m_blank[digit] || (m_lz && digit >= 1 && upper == 16'h0);
    o.an[digit] = 1'b0;
    o.seg = darkd ? 7'b1111111 : gl[upper[3:0]];
    o.dp  = ~m_dp[digit];
    return o;
  endfunction

  // One clock: predict the pins for this edge, then advance the model.
  task automatic step();
    pins_t e;
    e = model_out();
    @(posedge mclk);
    expq.push_back(e);
    if (rst) begin
      t = 0; m_val = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;
    end else begin
      t++;
      if (load) begin
        m_val = value; m_dp = dp_in; m_blank = blank; m_lz = lz_blank;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                         input logic [3:0] b, input logic lz);
    value = v; dp_in = d; blank = b; lz_blank = lz; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Advance until the next cycle sits at the given slot phase (and digit,
  // unless digit < 0). Bounded so the bench cannot stall.
  task automatic run_to(input int phase, input int digit);
    int n = 0;
    while (!((t % P) == phase && (digit < 0 || ((t / P) % 4) == digit))) begin
      step();
      n++;
      if (n > 64) begin
        tests++; fails++;
        $display("FAIL run_to phase=%0d digit=%0d not reached, t=%0d", phase, digit, t);
        return;
      end
    end
  endtask

  // Monitor: every predicted edge is checked half a cycle later.
  always @(negedge mclk) begin
    pins_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      tests++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL pins @%0t: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                 $time, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  initial begin
    t = 0; m_val = '0; m_dp = '0; m_blank = '0; m_lz = 1'b0;
    rst = 1'b1; value = '0; dp_in = '0; blank = '0; lz_blank = 1'b0; load = 1'b0;

    // reset, then free-running scan of the zero shadow
    run(3);
    rst = 1'b0;
    run(20);

    // plain value
    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
    run(20);

    // leading-zero suppression
    do_load(16'h0070, 4'b0000, 4'b0000, 1'b1);
    run(17);
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    run(17);

    // forced blank with decimal point
    do_load(16'h8888, 4'b0010, 4'b0100, 1'b0);
    run(17);
    do_load(16'h0005, 4'b0010, 4'b0000, 1'b1);
    run(17);

    // mid-slot load, then load coinciding with the digit wrap
    do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
    run_to(2, 1);
    do_load(16'hFFFF, 4'b0000, 4'b0000, 1'b0);
    run(6);
    run_to(P - 1, -1);
    do_load(16'hABCD, 4'b1001, 4'b0000, 1'b0);
    run(10);

    // continuous load tracks the inputs
    load = 1'b1;
    for (int i = 0; i < 24; i++) begin
      value = 16'($urandom); dp_in = 4'($urandom); blank = 4'($urandom); lz_blank = 1'($urandom);
      step();
    end
    load = 1'b0;

    // randomized loads
    for (int i = 0; i < 300; i++) begin
      value    = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in    = 4'($urandom);
      blank    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      lz_blank = 1'($urandom);
      load     = ($urandom_range(0, 5) == 0);
      step();
    end
    load = 1'b0;

    // reset in the middle of the digit-2 slot
    do_load(16'h4321, 4'b1111, 4'b0000, 1'b0);
    run_to(2, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(20);

    @(negedge mclk);
    #1;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending predictions, want 0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
